// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The optional FETCH_PERF_CNT_EN build is handled in fetch_unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer. Flush wins over push/pop; push and pop
// may happen together, including when the buffer is full.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_empty   = (r_count == 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, memory request/response tracking, redirect
// flush and a 2-entry decode buffer. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PCSrc,
  input  logic [31:0]  branchTarget,
  output logic         imemReq,
  output logic [31:0]  imemAddr,
  input  logic         imemReady,
  input  logic         imemValid,
  input  logic [31:0]  imemRdata,
  output logic         instrValid,
  output logic [31:0]  instr,
  output logic [31:0]  instrPC,
  input  logic         instrReady,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]  fetchCount,
  output logic [31:0]  redirectCount,
`endif
  output fetch_state_t o_state
);

  // Handshakes: a request is accepted when imemReq && imemReady; imemAddr is
  // held until then. An instruction is delivered when instrValid && instrReady.
  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [1:0]   r_outstanding;
  logic [1:0]   w_out_next;
  logic [31:0]  w_target;
  logic [2:0]   w_inflight;
  logic         w_accept;
  logic         w_resp;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_target = branchTarget & 32'hFFFF_FFFC;
  assign w_pop    = !w_empty && instrReady;

  // A slot freed by this cycle's pop is already available for a new request,
  // which is what allows one instruction per cycle with only two entries.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count} - {2'b00, w_pop};
  assign imemReq    = (r_state == FETCH) && (w_inflight < DEPTH);
  assign imemAddr   = r_pc;
  assign w_accept   = imemReq && imemReady;
  assign w_resp     = imemValid && (r_outstanding != 2'd0);

  // Outstanding requests since the last redirect are contiguous and end at
  // r_pc-4, so the oldest one sits at r_pc - 4*outstanding.
  assign w_push_data.instr = imemRdata;
  assign w_push_data.pc    = r_pc - {28'd0, r_outstanding, 2'b00};
  assign w_push = w_resp && (r_state == FETCH) && !PCSrc && (!w_full || w_pop);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_out_next   = r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
    if (w_accept) begin
      w_pc_next = r_pc + 32'd4;
    end
    if (PCSrc) begin
      w_pc_next = w_target;
    end
    case (r_state)
      BOOT:    w_state_next = FETCH;
      FETCH:   if (PCSrc && (w_out_next != 2'd0)) w_state_next = DRAIN;
      DRAIN:   if (!PCSrc && (r_outstanding == 2'd0)) w_state_next = FETCH;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_outstanding <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_outstanding <= w_out_next;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (PCSrc),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign instrValid = !w_empty;
  assign instr      = w_empty ? 32'd0 : w_head.instr;
  assign instrPC    = w_empty ? 32'd0 : w_head.pc;
  assign o_state    = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt    <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      r_fetch_cnt    <= r_fetch_cnt + {31'd0, w_pop};
      r_redirect_cnt <= r_redirect_cnt + {31'd0, PCSrc};
    end
  end

  assign fetchCount    = r_fetch_cnt;
  assign redirectCount = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode behaviour checked against a
// program-order model (expected request and delivery PCs per redirect epoch).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         PCSrc;
  logic [31:0]  branchTarget;
  logic         imemReq;
  logic [31:0]  imemAddr;
  logic         imemReady;
  logic         imemValid;
  logic [31:0]  imemRdata;
  logic         instrValid;
  logic [31:0]  instr;
  logic [31:0]  instrPC;
  logic         instrReady;
  fetch_state_t o_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  fetchCount;
  logic [31:0]  redirectCount;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCSrc        (PCSrc),
    .branchTarget (branchTarget),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemValid    (imemValid),
    .imemRdata    (imemRdata),
    .instrValid   (instrValid),
    .instr        (instr),
    .instrPC      (instrPC),
    .instrReady   (instrReady),
`ifdef FETCH_PERF_CNT_EN
    .fetchCount   (fetchCount),
    .redirectCount(redirectCount),
`endif
    .o_state      (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic pct_hit(input int p);
    return ($urandom_range(1, 100) <= p);
  endfunction

  // ---------------- stimulus knobs (written by the main sequence) ----------------
  int          rdy_pct = 100;
  int          vld_pct = 100;
  int          irdy_pct = 100;
  int          rdy_lo_from = -1;
  int          rdy_lo_to = -1;
  int          irdy_lo_from = -1;
  int          irdy_lo_to = -1;
  int          redir_at = -1;
  logic [31:0] redir_tgt = 32'h0;

  // ---------------- monitor-owned state ----------------
  logic        s_acc = 1'b0;
  logic        s_resp = 1'b0;
  logic [31:0] s_acc_addr = 32'h0;
  logic [31:0] exp_pc;
  logic [31:0] req_pc;
  int          live;
  logic        prev_stall;
  logic        prev_redir;
  logic [31:0] prev_addr;
  int          n_deliv = 0;
  int          perf_deliv;
  int          perf_redir;

  // ---------------- driver: memory model + decode + redirect ----------------
  int          cyc = 0;
  logic [31:0] pend_q[$];

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!rst_n) begin
      pend_q.delete();
    end else begin
      if (s_resp && pend_q.size() > 0) void'(pend_q.pop_front());
      if (s_acc) pend_q.push_back(s_acc_addr);
    end
    imemReady    = (cyc >= rdy_lo_from && cyc < rdy_lo_to) ? 1'b0 : pct_hit(rdy_pct);
    imemValid    = (pend_q.size() > 0) && pct_hit(vld_pct);
    imemRdata    = imemValid ? mem_word(pend_q[0]) : $urandom;
    instrReady   = (cyc >= irdy_lo_from && cyc < irdy_lo_to) ? 1'b0 : pct_hit(irdy_pct);
    PCSrc        = (cyc == redir_at);
    branchTarget = PCSrc ? redir_tgt : $urandom;
  end

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc     = RESET_PC;
      req_pc     = RESET_PC;
      live       = 0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      s_acc      = 1'b0;
      s_resp     = 1'b0;
      perf_deliv = 0;
      perf_redir = 0;
    end else begin
      s_acc      = imemReq && imemReady;
      s_acc_addr = imemAddr;
      s_resp     = imemValid;
      if (prev_stall && imemReq) check_eq("addr_hold", imemAddr, prev_addr);
      if (prev_redir) check_eq("flush_valid", 32'(instrValid), 32'd0);
      if (s_acc) begin
        check_eq("req_addr", imemAddr, req_pc);
        req_pc = req_pc + 32'd4;
        live++;
      end
      if (instrValid && instrReady) begin
        check_eq("deliv_pc", instrPC, exp_pc);
        check_eq("deliv_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        live--;
        n_deliv++;
        perf_deliv++;
      end
      if (s_acc) check_eq("buffered_le2", 32'(live <= 2), 32'd1);
      if (PCSrc) begin
        exp_pc = {branchTarget[31:2], 2'b00};
        req_pc = {branchTarget[31:2], 2'b00};
        live   = 0;
        perf_redir++;
      end
      prev_stall = imemReq && !imemReady && !PCSrc;
      prev_redir = PCSrc;
      prev_addr  = imemAddr;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_req(input string tag);
    int t = 0;
    @(negedge clk);
    while (!imemReq && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(imemReq), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    @(negedge clk);
    while (!instrValid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(instrValid), 32'd1);
  endtask

  task automatic pulse_reset(output int k);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 k = cyc;
  endtask

  // ---------------- main sequence ----------------
  int          k;
  int          d0;
  logic [31:0] held_instr;
  logic [31:0] held_pc;

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; branchTarget = 32'h0;
    imemReady = 1'b0; imemValid = 1'b0; imemRdata = 32'h0; instrReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req",    32'(imemReq),    32'd0);
    check_eq("rst_addr",   imemAddr,        RESET_PC);
    check_eq("rst_valid",  32'(instrValid), 32'd0);
    check_eq("rst_instr",  instr,           32'd0);
    check_eq("rst_pc",     instrPC,         32'd0);

    // zero-wait streaming from reset
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("boot_req",   32'(imemReq),    32'd0);
    check_eq("boot_state", 32'(o_state),    32'(BOOT));
    @(negedge clk);
    check_eq("first_req",  32'(imemReq),    32'd1);
    check_eq("first_addr", imemAddr,        32'h0);
    repeat (2) @(negedge clk);
    check_eq("first_valid", 32'(instrValid), 32'd1);
    check_eq("first_pc",    instrPC,         32'h0);
    #1 d0 = n_deliv;
    repeat (10) @(negedge clk);
    #1 check_eq("throughput", 32'(n_deliv - d0), 32'd10);

    // memory not ready for three cycles on address 0x8
    pulse_reset(k);
    rdy_lo_from = k + 3;
    rdy_lo_to   = k + 6;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req",  32'(imemReq), 32'd1);
      check_eq("stall_addr", imemAddr,     32'h8);
      @(negedge clk);
    end
    check_eq("stall_acc_req",  32'(imemReq && imemReady), 32'd1);
    check_eq("stall_acc_addr", imemAddr, 32'h8);

    // decode stalled for five cycles
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 k = cyc;
    irdy_lo_from = k + 1;
    irdy_lo_to   = k + 6;
    repeat (2) @(negedge clk);
    held_instr = instr;
    held_pc    = instrPC;
    check_eq("hold_valid", 32'(instrValid), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("hold_instr", instr,         held_instr);
    check_eq("hold_pc",    instrPC,       held_pc);
    check_eq("hold_noreq", 32'(imemReq),  32'd0);
    @(negedge clk);
    check_eq("resume_pc",  instrPC,       held_pc);

    // redirect with two responses outstanding
    repeat (5) @(negedge clk);
    @(posedge clk);
    vld_pct = 0;
    repeat (6) @(negedge clk);
    check_eq("sat_noreq", 32'(imemReq), 32'd0);
    @(posedge clk);
    #2 k = cyc;
    redir_at = k + 1; redir_tgt = 32'h0000_0103; vld_pct = 100;
    repeat (3) @(negedge clk);
    check_eq("drain_state", 32'(o_state),    32'(DRAIN));
    check_eq("drain_valid", 32'(instrValid), 32'd0);
    wait_req("redir_req");
    check_eq("redir_addr", imemAddr, 32'h100);
    wait_valid("redir_valid");
    check_eq("redir_first_pc", instrPC, 32'h100);

    // second redirect while already draining
    repeat (4) @(negedge clk);
    @(posedge clk);
    vld_pct = 0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 k = cyc;
    redir_at = k + 1; redir_tgt = 32'h0000_0200;
    repeat (3) @(negedge clk);
    check_eq("drain2_state", 32'(o_state), 32'(DRAIN));
    @(posedge clk);
    #2 k = cyc;
    redir_at = k + 1; redir_tgt = 32'h0000_030E; vld_pct = 100;
    repeat (3) @(negedge clk);
    check_eq("drain3_state", 32'(o_state), 32'(DRAIN));
    wait_req("redir2_req");
    check_eq("redir2_addr", imemAddr, 32'h30C);
    wait_valid("redir2_valid");
    check_eq("redir2_first_pc", instrPC, 32'h30C);

    // PC wrap
    @(posedge clk);
    #2 k = cyc;
    redir_at = k + 1; redir_tgt = 32'hFFFF_FFFC;
    repeat (2) @(negedge clk);
    wait_req("wrap_req0");
    check_eq("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("wrap_req1",  32'(imemReq), 32'd1);
    check_eq("wrap_addr1", imemAddr,     32'h0);

    // mid-stream reset
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 32'(instrValid), 32'd0);
    check_eq("mr_req",   32'(imemReq),    32'd0);
    check_eq("mr_addr",  imemAddr,        RESET_PC);
    check_eq("mr_state", 32'(o_state),    32'(BOOT));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mr_first_req",  32'(imemReq), 32'd1);
    check_eq("mr_first_addr", imemAddr,     RESET_PC);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      if (i % 100 == 0) begin
        rdy_pct  = $urandom_range(30, 100);
        vld_pct  = $urandom_range(30, 100);
        irdy_pct = $urandom_range(30, 100);
      end
      #2;
      if ($urandom_range(0, 39) == 0) begin
        redir_at  = cyc + 1;
        redir_tgt = $urandom;
      end
      if ($urandom_range(0, 59) == 0) begin
        rdy_lo_from = cyc + 1;
        rdy_lo_to   = cyc + 1 + $urandom_range(1, 5);
      end
    end

    @(posedge clk);
    rdy_pct = 100; vld_pct = 100; irdy_pct = 100;
    wait_valid("final_flow");
`ifdef FETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    check_eq("perf_fetch",    fetchCount,    32'(perf_deliv));
    check_eq("perf_redirect", redirectCount, 32'(perf_redir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
